// File: rtl/mips16_load_store_unit.sv
// Load/store unit between the MEM stage and a 16-bit word-organised data memory.
// Adds byte loads with extension, byte stores by read-modify-write, and misaligned-word errors.
module mips16_load_store_unit #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    typedef enum logic [0:0] {IDLE, RMW_WR} state_t;

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] merge_reg, merge_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              resp_valid_reg, resp_valid_next;
    logic [DATA_W-1:0] resp_rdata_reg, resp_rdata_next;
    logic              resp_err_reg, resp_err_next;

    logic              misaligned;
    logic [7:0]        load_byte;
    logic [DATA_W-1:0] load_ext;
    logic [DATA_W-1:0] merge_word;

    assign misaligned = !req_byte && req_addr[0];
    assign load_byte  = req_addr[0] ? mem_read_data[15:8] : mem_read_data[7:0];
    assign load_ext   = req_signed ? {{(DATA_W-8){load_byte[7]}}, load_byte}
                                   : {{(DATA_W-8){1'b0}}, load_byte};

    // Byte lane addressed by req_addr[0] takes the store byte; the other lane keeps memory data
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_merge_lane
            assign merge_word[gi*8 +: 8] = (req_addr[0] == 1'(gi)) ? req_wdata[7:0]
                                                                    : mem_read_data[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        merge_next      = merge_reg;
        addr_next       = addr_reg;
        resp_valid_next = 1'b0;
        resp_rdata_next = resp_rdata_reg;
        resp_err_next   = 1'b0;
        req_ready       = 1'b0;
        mem_read        = 1'b0;
        mem_write_en    = 1'b0;
        mem_access_addr = '0;
        mem_write_data  = '0;
        case (state_reg)
            IDLE: begin
                req_ready = reset_n;
                if (reset_n && req_valid) begin
                    if (misaligned) begin
                        resp_valid_next = 1'b1;
                        resp_rdata_next = '0;
                        resp_err_next   = 1'b1;
                    end else if (req_write && req_byte) begin
                        mem_read        = 1'b1;
                        mem_access_addr = req_addr;
                        merge_next      = merge_word;
                        addr_next       = req_addr;
                        state_next      = RMW_WR;
                    end else if (req_write) begin
                        mem_write_en    = 1'b1;
                        mem_access_addr = req_addr;
                        mem_write_data  = req_wdata;
                        resp_valid_next = 1'b1;
                        resp_rdata_next = '0;
                    end else begin
                        mem_read        = 1'b1;
                        mem_access_addr = req_addr;
                        resp_valid_next = 1'b1;
                        resp_rdata_next = req_byte ? load_ext : mem_read_data;
                    end
                end
            end
            RMW_WR: begin
                // Write strobe must fall as soon as reset asserts, before the flops clear
                if (reset_n) begin
                    mem_write_en    = 1'b1;
                    mem_access_addr = addr_reg;
                    mem_write_data  = merge_reg;
                end
                resp_valid_next = 1'b1;
                resp_rdata_next = '0;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            merge_reg      <= '0;
            addr_reg       <= '0;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= '0;
            resp_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            merge_reg      <= merge_next;
            addr_reg       <= addr_next;
            resp_valid_reg <= resp_valid_next;
            resp_rdata_reg <= resp_rdata_next;
            resp_err_reg   <= resp_err_next;
        end
    end

    assign resp_valid = resp_valid_reg;
    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;

endmodule

// File: tb/tb_mips16_load_store_unit.sv
// Directed bench for mips16_load_store_unit with a behavioural 16-bit word memory.
// Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
module tb_mips16_load_store_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid, req_ready, req_write, req_byte, req_signed;
    logic [15:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [15:0] resp_rdata;
    logic        mem_read, mem_write_en;
    logic [15:0] mem_access_addr, mem_write_data, mem_read_data;

    logic [15:0] mem [0:32767];
    logic        pre_we = 1'b0;
    logic [14:0] pre_idx = '0;
    logic [15:0] pre_data = '0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        else if (mem_write_en) mem[mem_access_addr[15:1]] <= mem_write_data;
    end
    assign mem_read_data = mem[mem_access_addr[15:1]];

    mips16_load_store_unit #(.ADDR_W(16), .DATA_W(16)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_byte(req_byte), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_read(mem_read), .mem_write_en(mem_write_en), .mem_access_addr(mem_access_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    task automatic step;
        @(posedge clock); #1;
    endtask

    task automatic sample;
        @(negedge clock);
    endtask

    task automatic drive(input logic w, input logic b, input logic s, input logic [15:0] a, input logic [15:0] d);
        req_valid = 1'b1; req_write = w; req_byte = b; req_signed = s; req_addr = a; req_wdata = d;
    endtask

    task automatic drive_idle;
        req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic preload(input logic [14:0] idx, input logic [15:0] data);
        pre_we = 1'b1; pre_idx = idx; pre_data = data;
        step;
        pre_we = 1'b0;
    endtask

    task automatic test_reset;
        drive_idle;
        preload(15'h0008, 16'h5A5A);
        preload(15'h0010, 16'h80F3);
        preload(15'h0018, 16'h1234);
        preload(15'h0020, 16'h4242);
        preload(15'h0028, 16'h1111);
        drive(1'b1, 1'b0, 1'b0, 16'h0010, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            sample;
            vectors++; if (mem_write_en !== 1'b0) begin miscompares++; $display("FAIL rst_we got %h exp 0", mem_write_en); end
            vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready got %h exp 0", req_ready); end
            vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_resp_valid got %h exp 0", resp_valid); end
            vectors++; if (mem_access_addr !== 16'h0000) begin miscompares++; $display("FAIL rst_addr got %h exp 0000", mem_access_addr); end
            vectors++; if (mem_write_data !== 16'h0000) begin miscompares++; $display("FAIL rst_wdata got %h exp 0000", mem_write_data); end
        end
        drive_idle;
        #2 reset_n = 1'b1;
        step; sample;
        vectors++; if (mem[15'h0008] !== 16'h5A5A) begin miscompares++; $display("FAIL rst_mem got %h exp 5a5a", mem[15'h0008]); end
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_after_valid got %h exp 0", resp_valid); end
        vectors++; if (resp_rdata !== 16'h0000) begin miscompares++; $display("FAIL rst_rdata got %h exp 0000", resp_rdata); end
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_after_ready got %h exp 1", req_ready); end
    endtask

    task automatic test_word_store_load;
        step; drive(1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF); sample;
        vectors++; if (mem_write_en !== 1'b1) begin miscompares++; $display("FAIL wst_we got %h exp 1", mem_write_en); end
        vectors++; if (mem_read !== 1'b0) begin miscompares++; $display("FAIL wst_read got %h exp 0", mem_read); end
        vectors++; if (mem_access_addr !== 16'h0010) begin miscompares++; $display("FAIL wst_addr got %h exp 0010", mem_access_addr); end
        vectors++; if (mem_write_data !== 16'hBEEF) begin miscompares++; $display("FAIL wst_wdata got %h exp beef", mem_write_data); end
        step; drive(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000); sample;
        vectors++; if (resp_valid !== 1'b1) begin miscompares++; $display("FAIL wst_resp_valid got %h exp 1", resp_valid); end
        vectors++; if (resp_rdata !== 16'h0000) begin miscompares++; $display("FAIL wst_resp_rdata got %h exp 0000", resp_rdata); end
        vectors++; if (mem_read !== 1'b1) begin miscompares++; $display("FAIL wld_read got %h exp 1", mem_read); end
        step; drive_idle; sample;
        vectors++; if (resp_valid !== 1'b1) begin miscompares++; $display("FAIL wld_resp_valid got %h exp 1", resp_valid); end
        vectors++; if (resp_rdata !== 16'hBEEF) begin miscompares++; $display("FAIL wld_rdata got %h exp beef", resp_rdata); end
        vectors++; if (resp_err !== 1'b0) begin miscompares++; $display("FAIL wld_err got %h exp 0", resp_err); end
        vectors++; if (mem_read !== 1'b0 || mem_access_addr !== 16'h0000) begin miscompares++; $display("FAIL idle_outputs got read=%h addr=%h exp 0 0000", mem_read, mem_access_addr); end
        step; sample;
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL wld_pulse got %h exp 0", resp_valid); end
        vectors++; if (resp_rdata !== 16'hBEEF) begin miscompares++; $display("FAIL wld_hold got %h exp beef", resp_rdata); end
    endtask

    task automatic test_back_to_back;
        step; drive(1'b0, 1'b1, 1'b1, 16'h0021, 16'h0000); sample;
        vectors++; if (mem_read !== 1'b1 || mem_access_addr !== 16'h0021) begin miscompares++; $display("FAIL bld_strobe got read=%h addr=%h exp 1 0021", mem_read, mem_access_addr); end
        step; drive(1'b0, 1'b1, 1'b0, 16'h0021, 16'h0000); sample;
        vectors++; if (resp_valid !== 1'b1 || resp_rdata !== 16'hFF80) begin miscompares++; $display("FAIL bld_hi_signed got v=%h d=%h exp 1 ff80", resp_valid, resp_rdata); end
        step; drive(1'b0, 1'b1, 1'b1, 16'h0020, 16'h0000); sample;
        vectors++; if (resp_valid !== 1'b1 || resp_rdata !== 16'h0080) begin miscompares++; $display("FAIL bld_hi_unsigned got v=%h d=%h exp 1 0080", resp_valid, resp_rdata); end
        step; drive(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000); sample;
        vectors++; if (resp_valid !== 1'b1 || resp_rdata !== 16'hFFF3) begin miscompares++; $display("FAIL bld_lo_signed got v=%h d=%h exp 1 fff3", resp_valid, resp_rdata); end
        step; drive_idle; sample;
        vectors++; if (resp_valid !== 1'b1 || resp_rdata !== 16'h00F3) begin miscompares++; $display("FAIL bld_lo_unsigned got v=%h d=%h exp 1 00f3", resp_valid, resp_rdata); end
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL bld_ready got %h exp 1", req_ready); end
    endtask

    task automatic test_byte_store;
        step; drive(1'b1, 1'b1, 1'b0, 16'h0031, 16'h77AB); sample;
        vectors++; if (req_ready !== 1'b1 || mem_read !== 1'b1 || mem_write_en !== 1'b0) begin miscompares++; $display("FAIL bst_acc got rdy=%h rd=%h we=%h exp 1 1 0", req_ready, mem_read, mem_write_en); end
        vectors++; if (mem_access_addr !== 16'h0031) begin miscompares++; $display("FAIL bst_acc_addr got %h exp 0031", mem_access_addr); end
        step; drive(1'b1, 1'b1, 1'b0, 16'h0030, 16'h99CD); sample;
        vectors++; if (req_ready !== 1'b0 || mem_write_en !== 1'b1 || mem_read !== 1'b0) begin miscompares++; $display("FAIL bst_rmw got rdy=%h we=%h rd=%h exp 0 1 0", req_ready, mem_write_en, mem_read); end
        vectors++; if (mem_access_addr !== 16'h0031 || mem_write_data !== 16'hAB34) begin miscompares++; $display("FAIL bst_rmw_data got addr=%h data=%h exp 0031 ab34", mem_access_addr, mem_write_data); end
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL bst_early_resp got %h exp 0", resp_valid); end
        step; sample;
        vectors++; if (resp_valid !== 1'b1 || resp_rdata !== 16'h0000 || resp_err !== 1'b0) begin miscompares++; $display("FAIL bst_resp got v=%h d=%h e=%h exp 1 0000 0", resp_valid, resp_rdata, resp_err); end
        vectors++; if (mem[15'h0018] !== 16'hAB34) begin miscompares++; $display("FAIL bst_mem_hi got %h exp ab34", mem[15'h0018]); end
        vectors++; if (req_ready !== 1'b1 || mem_read !== 1'b1 || mem_write_en !== 1'b0) begin miscompares++; $display("FAIL bst2_acc got rdy=%h rd=%h we=%h exp 1 1 0", req_ready, mem_read, mem_write_en); end
        step; drive_idle; sample;
        vectors++; if (mem_write_en !== 1'b1 || mem_write_data !== 16'hABCD) begin miscompares++; $display("FAIL bst2_rmw got we=%h data=%h exp 1 abcd", mem_write_en, mem_write_data); end
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL bst2_early_resp got %h exp 0", resp_valid); end
        step; sample;
        vectors++; if (resp_valid !== 1'b1) begin miscompares++; $display("FAIL bst2_resp got %h exp 1", resp_valid); end
        vectors++; if (mem[15'h0018] !== 16'hABCD) begin miscompares++; $display("FAIL bst_mem_lo got %h exp abcd", mem[15'h0018]); end
    endtask

    task automatic test_misaligned;
        step; drive(1'b0, 1'b0, 1'b0, 16'h0041, 16'h0000); sample;
        vectors++; if (mem_read !== 1'b0 || mem_write_en !== 1'b0) begin miscompares++; $display("FAIL mis_strobe got rd=%h we=%h exp 0 0", mem_read, mem_write_en); end
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL mis_ready got %h exp 1", req_ready); end
        step; drive(1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000); sample;
        vectors++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 16'h0000) begin miscompares++; $display("FAIL mis_resp got v=%h e=%h d=%h exp 1 1 0000", resp_valid, resp_err, resp_rdata); end
        vectors++; if (mem_read !== 1'b1) begin miscompares++; $display("FAIL mis_next_accept got %h exp 1", mem_read); end
        step; drive_idle; sample;
        vectors++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 16'h4242) begin miscompares++; $display("FAIL mis_next_resp got v=%h e=%h d=%h exp 1 0 4242", resp_valid, resp_err, resp_rdata); end
    endtask

    task automatic test_reset_mid_rmw;
        step; drive(1'b1, 1'b1, 1'b0, 16'h0050, 16'h0055); sample;
        vectors++; if (mem_read !== 1'b1) begin miscompares++; $display("FAIL rrmw_acc got %h exp 1", mem_read); end
        step; drive_idle; sample;
        vectors++; if (mem_write_en !== 1'b1 || mem_write_data !== 16'h1155) begin miscompares++; $display("FAIL rrmw_wr got we=%h data=%h exp 1 1155", mem_write_en, mem_write_data); end
        #1 reset_n = 1'b0;
        #1;
        vectors++; if (mem_write_en !== 1'b0) begin miscompares++; $display("FAIL rrmw_async_drop got %h exp 0", mem_write_en); end
        step; sample;
        vectors++; if (mem[15'h0028] !== 16'h1111) begin miscompares++; $display("FAIL rrmw_mem got %h exp 1111", mem[15'h0028]); end
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rrmw_resp_in_rst got %h exp 0", resp_valid); end
        #2 reset_n = 1'b1;
        step; sample;
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rrmw_resp_after got %h exp 0", resp_valid); end
        vectors++; if (req_ready !== 1'b1 || mem_write_en !== 1'b0) begin miscompares++; $display("FAIL rrmw_idle got rdy=%h we=%h exp 1 0", req_ready, mem_write_en); end
        vectors++; if (mem[15'h0028] !== 16'h1111) begin miscompares++; $display("FAIL rrmw_mem_after got %h exp 1111", mem[15'h0028]); end
    endtask

    initial begin
        test_reset;
        test_word_store_load;
        test_back_to_back;
        test_byte_store;
        test_misaligned;
        test_reset_mid_rmw;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mips16_load_store_unit.md
# mips16_load_store_unit

Load/store unit for the MIPS16 core. It sits directly upstream of the data memory: it takes load/store requests from the MEM pipeline stage and drives the memory's read strobe, write enable, address and write data. The memory is 16-bit word-organised and reads combinationally. This block adds byte loads (sign- or zero-extended), byte stores by two-cycle read-modify-write, a registered load response, and misaligned-word detection.

## Interface
Parameters:
- ADDR_W, 16, byte address width
- DATA_W, 16, data width; only 16 is supported

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when req_valid && req_ready
- req_write  in  1  1 = store, 0 = load
- req_byte  in  1  1 = byte access, 0 = word access
- req_signed  in  1  byte load: 1 = sign-extend, 0 = zero-extend
- req_addr  in  16  byte address
- req_wdata  in  16  store data; byte store uses [7:0]
- resp_valid  out  1  one-cycle pulse when an accepted request completes
- resp_rdata  out  16  load result; 0 for stores and errors
- resp_err  out  1  qualified by resp_valid; misaligned word access
- mem_read  out  1  to data memory read strobe
- mem_write_en  out  1  to data memory write enable
- mem_access_addr  out  16  to data memory; word select is bits [15:1]
- mem_write_data  out  16  to data memory
- mem_read_data  in  16  from data memory, combinational

## Operation
- Byte order is little-endian: addr[0]=0 selects bits [7:0], addr[0]=1 selects bits [15:8].
- The FSM has two states: IDLE and RMW_WR.
- IDLE:
  - req_ready=1.
  - Memory outputs are combinational from the req_* inputs.
  - They are gated by req_valid.
- Word load, addr[0]=0:
  - mem_read=1, mem_access_addr=req_addr.
  - mem_read_data is captured at the edge into resp_rdata.
- Byte load:
  - mem_read=1, mem_access_addr=req_addr.
  - The selected byte is extended to 16 bits per req_signed and captured.
- Word store, addr[0]=0:
  - mem_write_en=1, mem_write_data=req_wdata.
  - The memory writes at the same edge.
- Byte store, acceptance cycle (IDLE):
  - mem_read=1, mem_write_en=0.
  - The merged word (mem_read_data with the selected byte replaced by req_wdata[7:0]) is registered.
  - req_addr is registered.
  - Next state is RMW_WR.
- RMW_WR:
  - req_ready=0.
  - mem_write_en=1, mem_read=0.
  - mem_access_addr and mem_write_data come from the captured registers.
  - Next state is IDLE.
- Word access with addr[0]=1:
  - The request is accepted with no memory strobe.
  - Response is resp_err=1, resp_rdata=0.
- When IDLE and req_valid=0, mem_read, mem_write_en, mem_access_addr and mem_write_data are all 0.
- resp_rdata holds its value until the next response. A store response sets it to 0.

## Timing
- Reset values: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, merge/address registers=0.
- While reset_n=0: req_ready=0, mem_read=0, mem_write_en=0, mem_access_addr=0, mem_write_data=0. All memory strobes are forced low.
- Latency from acceptance edge to resp_valid:
  - 1 cycle for loads, word stores and errors.
  - 2 cycles for byte stores.
- Throughput:
  - One request per cycle for everything except byte stores.
  - A byte store blocks the next request for exactly one cycle.
- resp_valid is high for exactly one cycle per accepted request. Responses are in order.
- Back-to-back loads with no idle cycles: resp_valid stays high continuously, and resp_rdata updates every cycle.
- A load to the same word immediately after a store sees the new data. The write lands at the edge before the load's combinational read.
- Reset asserted in RMW_WR: the write is abandoned (mem_write_en drops asynchronously), no response is issued, and the state returns to IDLE.
- req_* inputs are ignored while req_ready=0. The requester must hold them stable.

## Test plan
- Reset: hold reset_n=0 with req_valid=1 and req_write=1 → mem_write_en=0, req_ready=0, resp_valid=0 throughout. After release, memory is unchanged.
- Word store then load: store 0xBEEF to addr 0x0010, then load from 0x0010 → second response has resp_rdata=0xBEEF and resp_err=0, with one-cycle latency each.
- Byte loads:
  - Setup: word 0x80F3 at 0x0020.
  - addr 0x0021, signed → 0xFF80.
  - addr 0x0021, unsigned → 0x0080.
  - addr 0x0020, signed → 0xFFF3.
- Byte store read-modify-write: word 0x1234 at 0x0030; byte store 0xAB to 0x0031 → req_ready=0 for one cycle, mem_write_en high only in RMW_WR, word reads back as 0xAB34. A byte store 0xCD to 0x0030 then gives 0xABCD.
- Misaligned word access: word load from 0x0041 → mem_read=0, resp_valid with resp_err=1 and resp_rdata=0, and the next request is accepted the following cycle.
- Reset mid read-modify-write: byte store 0x55 to 0x0050 (old word 0x1111), assert reset_n=0 during RMW_WR → word stays 0x1111 and no resp_valid pulse occurs.
